aon_timer_sched: RTL and testbench

- APB-master sequencer that programs and monitors the always-on timer's APB slave on behalf of one requester, such as the PMU.
- Accepts a one-shot timeout request, writes LOAD and then CTRL.enable, and polls COUNTER until expiry.
- On expiry it pulses `wake`, then disables the timer.
- Sits in PD0 between the power-management requester and the timer slave port.

---
 rtl/aon_timer_sched.sv | 170 +++++++++++++++++
 tb/tb_aon_timer_sched.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aon_timer_sched.sv
// APB-master sequencer that loads, enables, polls and disables the always-on timer for one requester.
// Optional periodic mode: define AON_TIMER_SCHED_PERIODIC_EN to keep polling after each expiry.
module aon_timer_sched #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] TIMER_BASE = '0,
   parameter int                    WAIT_MAX   = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_WIDTH-1:0] req_ticks,
   input  logic                  cancel,
   output logic                  wake,
   output logic                  err,
   output logic                  busy,
   output logic                  m_psel,
   output logic                  m_penable,
   output logic                  m_pwrite,
   output logic [ADDR_WIDTH-1:0] m_paddr,
   output logic [DATA_WIDTH-1:0] m_pwdata,
   input  logic [DATA_WIDTH-1:0] m_prdata,
   input  logic                  m_pready,
   input  logic                  m_pslverr
);

   localparam int WCW = $clog2(WAIT_MAX + 1);
   localparam logic [ADDR_WIDTH-1:0] LOAD_ADDR  = TIMER_BASE;
   localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR  = TIMER_BASE + ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] COUNT_ADDR = TIMER_BASE + ADDR_WIDTH'(8);

   typedef enum logic [3:0] {IDLE, LD_S, LD_A, EN_S, EN_A, PL_S, PL_A, DS_S, DS_A} state_t;

   state_t                state;
   logic                  cancel_q;
   logic                  first_poll;
   logic [DATA_WIDTH-1:0] prev_cnt;
   logic [WCW-1:0]        wait_cnt;

   logic cancel_eff;
   logic expired;

   assign req_ready  = (state == IDLE);
   assign busy       = (state != IDLE);
   assign cancel_eff = cancel_q | cancel;
   // A read of 0 can be missed between polls, so a count that jumped up means the timer reloaded.
   assign expired    = (m_prdata == '0) || (!first_poll && (m_prdata > prev_cnt));

   // m_pwdata holds the captured request ticks for the whole LOAD transfer.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state      <= IDLE;
         cancel_q   <= 1'b0;
         first_poll <= 1'b0;
         prev_cnt   <= '0;
         wait_cnt   <= '0;
         wake       <= 1'b0;
         err        <= 1'b0;
         m_psel     <= 1'b0;
         m_penable  <= 1'b0;
         m_pwrite   <= 1'b0;
         m_paddr    <= '0;
         m_pwdata   <= '0;
      end else begin
         wake <= 1'b0;
         err  <= 1'b0;
         if (cancel && (state != IDLE)) cancel_q <= 1'b1;

         case (state)
            IDLE: begin
               if (req_valid) begin
                  cancel_q   <= 1'b0;
                  first_poll <= 1'b1;
                  prev_cnt   <= '0;
                  if (req_ticks == '0) begin
                     wake <= 1'b1;
                  end else begin
                     state     <= LD_S;
                     m_psel    <= 1'b1;
                     m_penable <= 1'b0;
                     m_pwrite  <= 1'b1;
                     m_paddr   <= LOAD_ADDR;
                     m_pwdata  <= req_ticks;
                  end
               end
            end

            LD_S, EN_S, PL_S, DS_S: begin
               m_penable <= 1'b1;
               wait_cnt  <= '0;
               case (state)
                  LD_S:    state <= LD_A;
                  EN_S:    state <= EN_A;
                  PL_S:    state <= PL_A;
                  default: state <= DS_A;
               endcase
            end

            LD_A, EN_A, PL_A, DS_A: begin
               if (!m_pready) begin
                  // Stalled slave: release the bus and give up, leaving the timer as it is.
                  if (wait_cnt == WCW'(WAIT_MAX - 1)) begin
                     state     <= IDLE;
                     m_psel    <= 1'b0;
                     m_penable <= 1'b0;
                     err       <= 1'b1;
                  end else begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end else if (state == DS_A) begin
                  state     <= IDLE;
                  m_psel    <= 1'b0;
                  m_penable <= 1'b0;
                  err       <= m_pslverr;
               end else begin
                  m_penable <= 1'b0;
                  if (m_pslverr || cancel_eff) begin
                     err      <= m_pslverr;
                     state    <= DS_S;
                     m_pwrite <= 1'b1;
                     m_paddr  <= CTRL_ADDR;
                     m_pwdata <= '0;
                  end else begin
                     case (state)
                        LD_A: begin
                           state    <= EN_S;
                           m_paddr  <= CTRL_ADDR;
                           m_pwdata <= DATA_WIDTH'(1);
                        end
                        EN_A: begin
                           state    <= PL_S;
                           m_pwrite <= 1'b0;
                           m_paddr  <= COUNT_ADDR;
                           m_pwdata <= '0;
                        end
                        default: begin
                           if (expired) begin
                              wake <= 1'b1;
`ifdef AON_TIMER_SCHED_PERIODIC_EN
                              state      <= PL_S;
                              first_poll <= 1'b1;
                              prev_cnt   <= '0;
`else
                              state    <= DS_S;
                              m_pwrite <= 1'b1;
                              m_paddr  <= CTRL_ADDR;
                              m_pwdata <= '0;
`endif
                           end else begin
                              state      <= PL_S;
                              prev_cnt   <= m_prdata;
                              first_poll <= 1'b0;
                           end
                        end
                     endcase
                  end
               end
            end

            default: begin
               state     <= IDLE;
               m_psel    <= 1'b0;
               m_penable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aon_timer_sched.sv
// Directed bench for aon_timer_sched with an APB timer slave model (countdown, reload on zero).
module tb_aon_timer_sched;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_ticks = '0;
   logic        cancel = 1'b0;
   logic        wake, err, busy;
   logic        m_psel, m_penable, m_pwrite;
   logic [31:0] m_paddr, m_pwdata, m_prdata;
   logic        m_pready, m_pslverr;

   int checks = 0;
   int errors = 0;

   always #5 PCLK = ~PCLK;

   aon_timer_sched dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_ready(req_ready), .req_ticks(req_ticks),
      .cancel(cancel), .wake(wake), .err(err), .busy(busy),
      .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
      .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
      .m_pready(m_pready), .m_pslverr(m_pslverr)
   );

   // Slave model controls (written only by the stimulus process)
   logic        slv_ready = 1'b1;
   logic        slv_err_en = 1'b0;
   logic [31:0] slv_err_addr = '0;
   logic        seq_mode = 1'b0;
   logic [31:0] seq_vals [4];

   // Slave model state and monitors (written only by the monitor process)
   logic [31:0] tload = '0, tcnt = '0;
   logic        tenable = 1'b0;
   int          seq_idx = 0;
   int          cyc = 0, en_cyc = 0;
   int          wake_cnt = 0, err_cnt = 0, psel_cnt = 0;
   int          wake_cyc[$];
   logic [31:0] t_addr[$];
   logic        t_wr[$];
   logic [31:0] t_data[$];

   assign m_pready  = slv_ready;
   assign m_pslverr = slv_err_en && m_psel && m_penable && (m_paddr == slv_err_addr);
   assign m_prdata  = seq_mode ? seq_vals[(seq_idx > 3) ? 3 : seq_idx] : tcnt;

   always @(posedge PCLK) begin
      cyc <= cyc + 1;
      if (wake) begin
         wake_cnt <= wake_cnt + 1;
         wake_cyc.push_back(cyc);
      end
      if (err) err_cnt <= err_cnt + 1;
      if (m_psel) psel_cnt <= psel_cnt + 1;
      if (tenable) tcnt <= (tcnt == 0) ? tload : tcnt - 1;
      if (m_psel && m_penable && m_pready) begin
         t_addr.push_back(m_paddr);
         t_wr.push_back(m_pwrite);
         t_data.push_back(m_pwrite ? m_pwdata : m_prdata);
         if (!m_pwrite && seq_mode) seq_idx <= seq_idx + 1;
         if (m_pwrite && m_paddr == 32'h0) tload <= m_pwdata;
         if (m_pwrite && m_paddr == 32'h4) begin
            tenable <= m_pwdata[0];
            if (m_pwdata[0]) begin
               tcnt   <= tload;
               en_cyc <= cyc;
            end
         end
      end
   end

   task automatic start_req(input logic [31:0] t);
      @(negedge PCLK);
      req_valid = 1'b1;
      req_ticks = t;
      @(negedge PCLK);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge PCLK);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      bit ok;
      PRESETn = 1'b0;
      repeat (2) @(negedge PCLK);
      checks++;
      if ({req_ready, busy, wake, err, m_psel, m_penable, m_pwrite} !== 7'b1000000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b, expected 1000000",
                  {req_ready, busy, wake, err, m_psel, m_penable, m_pwrite});
      end
      checks++;
      if ({m_paddr, m_pwdata} !== 64'h0) begin
         errors++;
         $display("FAIL reset_bus: got paddr=%0h pwdata=%0h, expected 0/0", m_paddr, m_pwdata);
      end
      PRESETn = 1'b1;
      start_req(32'd1000);
      repeat (3) @(negedge PCLK);
      ok = busy;
      PRESETn = 1'b0;
      #1;
      checks++;
      if (!ok || m_psel !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_midop: busy_before=%0b psel=%b busy=%b ready=%b, expected 1/0/0/1",
                  ok, m_psel, busy, req_ready);
      end
      @(negedge PCLK);
      PRESETn = 1'b1;
      @(negedge PCLK);
   endtask

   task automatic test_zero;
      int p0;
      p0 = psel_cnt;
      @(negedge PCLK);
      req_valid = 1'b1;
      req_ticks = 32'd0;
      @(negedge PCLK);
      checks++;
      if (wake !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_wake: wake=%b ready=%b busy=%b, expected 1/1/0", wake, req_ready, busy);
      end
      req_valid = 1'b0;
      @(negedge PCLK);
      checks++;
      if (wake !== 1'b0 || psel_cnt !== p0) begin
         errors++;
         $display("FAIL zero_nobus: wake=%b psel_cycles=%0d, expected 0/0", wake, psel_cnt - p0);
      end
   endtask

`ifndef AON_TIMER_SCHED_PERIODIC_EN
   task automatic test_basic;
      int n0, w0, n, bad, dt;
      bit ok;
      n0 = t_addr.size();
      w0 = wake_cnt;
      start_req(32'd20);
      wait_idle(200, ok);
      n = t_addr.size();
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_idle: busy after 200 cycles, expected idle"); end
      checks++;
      if (t_addr[n0] !== 32'h0 || t_wr[n0] !== 1'b1 || t_data[n0] !== 32'd20) begin
         errors++;
         $display("FAIL basic_load: got addr=%0h wr=%b data=%0d, expected 0/1/20",
                  t_addr[n0], t_wr[n0], t_data[n0]);
      end
      checks++;
      if (t_addr[n0+1] !== 32'h4 || t_wr[n0+1] !== 1'b1 || t_data[n0+1] !== 32'd1) begin
         errors++;
         $display("FAIL basic_enable: got addr=%0h wr=%b data=%0d, expected 4/1/1",
                  t_addr[n0+1], t_wr[n0+1], t_data[n0+1]);
      end
      bad = 0;
      for (int i = n0 + 2; i < n - 1; i++)
         if (t_addr[i] !== 32'h8 || t_wr[i] !== 1'b0) bad++;
      checks++;
      if (bad != 0 || n - n0 < 4) begin
         errors++;
         $display("FAIL basic_polls: got %0d bad of %0d transfers, expected 0 bad and >=4", bad, n - n0);
      end
      checks++;
      if (t_addr[n-1] !== 32'h4 || t_wr[n-1] !== 1'b1 || t_data[n-1] !== 32'd0) begin
         errors++;
         $display("FAIL basic_disable: got addr=%0h wr=%b data=%0d, expected 4/1/0",
                  t_addr[n-1], t_wr[n-1], t_data[n-1]);
      end
      checks++;
      if (wake_cnt - w0 != 1) begin
         errors++;
         $display("FAIL basic_wake_count: got %0d, expected 1", wake_cnt - w0);
      end
      dt = (wake_cyc.size() > 0) ? wake_cyc[wake_cyc.size()-1] - en_cyc : -1;
      checks++;
      if (dt < 21 || dt > 24) begin
         errors++;
         $display("FAIL basic_wake_time: got %0d cycles after enable, expected 21..24", dt);
      end
   endtask

   task automatic test_wrap;
      int n0, w0, n, nr, bad;
      bit ok;
      logic [31:0] exp_r [4];
      exp_r = '{32'd5, 32'd3, 32'd1, 32'd7};
      seq_vals = '{32'd5, 32'd3, 32'd1, 32'd7};
      seq_mode = 1'b1;
      n0 = t_addr.size();
      w0 = wake_cnt;
      start_req(32'd5);
      wait_idle(100, ok);
      seq_mode = 1'b0;
      n = t_addr.size();
      nr = 0;
      bad = 0;
      for (int i = n0; i < n; i++)
         if (!t_wr[i]) begin
            if (nr < 4 && t_data[i] !== exp_r[nr]) bad++;
            nr++;
         end
      checks++;
      if (!ok || nr != 4 || bad != 0) begin
         errors++;
         $display("FAIL wrap_reads: idle=%0b reads=%0d bad=%0d, expected 1/4/0", ok, nr, bad);
      end
      checks++;
      if (wake_cnt - w0 != 1 || t_addr[n-1] !== 32'h4 || t_data[n-1] !== 32'd0) begin
         errors++;
         $display("FAIL wrap_wake: wakes=%0d last addr=%0h data=%0d, expected 1/4/0",
                  wake_cnt - w0, t_addr[n-1], t_data[n-1]);
      end
   endtask
`endif

   task automatic test_cancel;
      int n0, w0, n;
      bit found, ok;
      n0 = t_addr.size();
      w0 = wake_cnt;
      start_req(32'd1000);
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge PCLK);
         if (m_psel && m_penable && !m_pwrite) begin
            found = 1'b1;
            break;
         end
      end
      cancel = 1'b1;
      @(negedge PCLK);
      cancel = 1'b0;
      wait_idle(50, ok);
      n = t_addr.size();
      checks++;
      if (!found || !ok) begin
         errors++;
         $display("FAIL cancel_idle: poll_seen=%0b idle=%0b, expected 1/1", found, ok);
      end
      checks++;
      if (t_addr[n-2] !== 32'h8 || t_wr[n-2] !== 1'b0 ||
          t_addr[n-1] !== 32'h4 || t_wr[n-1] !== 1'b1 || t_data[n-1] !== 32'd0) begin
         errors++;
         $display("FAIL cancel_seq: got %0h/%b then %0h/%b/%0d, expected 8/0 then 4/1/0",
                  t_addr[n-2], t_wr[n-2], t_addr[n-1], t_wr[n-1], t_data[n-1]);
      end
      checks++;
      if (wake_cnt != w0) begin
         errors++;
         $display("FAIL cancel_nowake: got %0d wakes, expected 0", wake_cnt - w0);
      end
      @(negedge PCLK);
      req_valid = 1'b1;
      req_ticks = 32'd0;
      @(negedge PCLK);
      req_valid = 1'b0;
      checks++;
      if (wake !== 1'b1) begin
         errors++;
         $display("FAIL cancel_new_req: wake=%b, expected 1", wake);
      end
      @(negedge PCLK);
   endtask

   task automatic test_slverr;
      int n0, w0, e0, n;
      bit ok;
      slv_err_en = 1'b1;
      slv_err_addr = 32'h0;
      n0 = t_addr.size();
      w0 = wake_cnt;
      e0 = err_cnt;
      start_req(32'd50);
      wait_idle(50, ok);
      slv_err_en = 1'b0;
      n = t_addr.size();
      checks++;
      if (!ok || err_cnt - e0 != 1 || wake_cnt != w0) begin
         errors++;
         $display("FAIL slverr_pulse: idle=%0b errs=%0d wakes=%0d, expected 1/1/0",
                  ok, err_cnt - e0, wake_cnt - w0);
      end
      checks++;
      if (n - n0 != 2 || t_addr[n0] !== 32'h0 || t_addr[n0+1] !== 32'h4 ||
          t_wr[n0+1] !== 1'b1 || t_data[n0+1] !== 32'd0) begin
         errors++;
         $display("FAIL slverr_seq: got %0d transfers, second %0h/%b/%0d, expected 2, 4/1/0",
                  n - n0, t_addr[n0+1], t_wr[n0+1], t_data[n0+1]);
      end
   endtask

   task automatic test_wait_timeout;
      int n0, acc;
      bit seen;
      slv_ready = 1'b0;
      n0 = t_addr.size();
      start_req(32'd50);
      acc = 0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge PCLK);
         if (err) begin
            seen = 1'b1;
            break;
         end
         if (m_penable) acc++;
      end
      checks++;
      if (!seen || acc != 16) begin
         errors++;
         $display("FAIL wait_err: err_seen=%0b stalled_access=%0d, expected 1/16", seen, acc);
      end
      checks++;
      if (m_psel !== 1'b0 || busy !== 1'b0 || t_addr.size() != n0) begin
         errors++;
         $display("FAIL wait_release: psel=%b busy=%b transfers=%0d, expected 0/0/0",
                  m_psel, busy, t_addr.size() - n0);
      end
      slv_ready = 1'b1;
      @(negedge PCLK);
   endtask

`ifdef AON_TIMER_SCHED_PERIODIC_EN
   task automatic test_periodic;
      int w0, k0, bad, wc, n;
      bit ok;
      w0 = wake_cnt;
      k0 = wake_cyc.size();
      start_req(32'd10);
      for (int i = 0; i < 200; i++) begin
         @(negedge PCLK);
         if (wake_cnt - w0 >= 3) break;
      end
      checks++;
      if (wake_cnt - w0 < 3) begin
         errors++;
         $display("FAIL periodic_count: got %0d wakes, expected >=3", wake_cnt - w0);
      end
      bad = 0;
      for (int i = k0; i + 1 < wake_cyc.size(); i++)
         if (wake_cyc[i+1] - wake_cyc[i] < 9 || wake_cyc[i+1] - wake_cyc[i] > 13) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL periodic_spacing: got %0d intervals outside 9..13, expected 0", bad);
      end
      cancel = 1'b1;
      @(negedge PCLK);
      cancel = 1'b0;
      wait_idle(50, ok);
      n = t_addr.size();
      wc = wake_cnt;
      repeat (40) @(negedge PCLK);
      checks++;
      if (!ok || t_addr[n-1] !== 32'h4 || t_data[n-1] !== 32'd0 || wake_cnt != wc) begin
         errors++;
         $display("FAIL periodic_cancel: idle=%0b last=%0h/%0d extra_wakes=%0d, expected 1, 4/0, 0",
                  ok, t_addr[n-1], t_data[n-1], wake_cnt - wc);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_zero;
`ifndef AON_TIMER_SCHED_PERIODIC_EN
      test_basic;
`endif
      test_cancel;
      test_slverr;
      test_wait_timeout;
`ifndef AON_TIMER_SCHED_PERIODIC_EN
      test_wrap;
`else
      test_periodic;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at 200000, expected finish");
      $fatal(1, "timeout");
   end

endmodule
